fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue between the instruction cache and the register/decode stage. Captures each `{pc, instruction}` pair delivered on an icache hit into a small in-order FIFO, presents the oldest entry to the decoder with a valid/ready handshake, and discards all contents on a pipeline flush or jump redirect. This decouples icache hit timing from decoder stalls, so fetch can run ahead while the ALU or memory stage holds the decoder.

## Interface
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `INSTSZ`, 32: instruction width.
- `WORDSZ`, 64: PC width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `in_valid` in 1: icache delivers an instruction this cycle (icache `operation_complete`).
- `in_instr` in INSTSZ: fetched instruction.
- `in_pc` in WORDSZ: PC of `in_instr`.
- `in_ready` out 1: queue can accept a push; equals `!full`.
- `out_valid` out 1: head entry is valid (`count != 0`).
- `out_instr` out INSTSZ: head instruction; `32'h0000_0013` (NOP) when empty.
- `out_pc` out WORDSZ: head PC; 0 when empty.
- `out_ready` in 1: decoder consumes the head this cycle (deasserted on decoder/ALU stall).
- `flush` in 1: flush or jump redirect (`flush | jmp`); empties the queue.
- `full` out 1: `count == DEPTH`; fetch must hold its PC.
- `count` out $clog2(DEPTH)+1: occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` registers of `{pc, instr}`, write pointer `wr_ptr`, read pointer `rd_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and occupancy counter `count`.
- Push: `push = in_valid && in_ready && !flush`. Writes `{in_pc, in_instr}` at `wr_ptr`; `wr_ptr` increments.
- Pop: `pop = out_valid && out_ready && !flush`. `rd_ptr` increments.
- `count` next value: `+1` on push only, `-1` on pop only, unchanged on both or neither.
- `in_valid` while full: the instruction is dropped and no state changes. Fetch is required to stall on `full`. There is no pop-through-full, so `in_ready` has no combinational path from `out_ready`.
- Push and pop in the same cycle at `count == DEPTH-1` are legal and leave `count` unchanged. At `count == 0`, a same-cycle pop cannot occur because `out_valid` is 0. There is no bypass.
- Flush takes priority over everything. On the next edge, `wr_ptr`, `rd_ptr` and `count` all become 0. A same-cycle push or pop is ignored. Stored data need not be cleared.
- Output mux is a combinational read of entry `rd_ptr` when `count != 0`, otherwise NOP/0.
- Order is strict FIFO, so instructions leave in exactly the order pushed.

## Timing
- Reset (async, `reset == 0`): `count=0`, pointers=0, `out_valid=0`, `out_instr=32'h0000_0013`, `out_pc=0`, `full=0`, `in_ready=1`. On reset release, the first edge with `in_valid` pushes normally.
- Push-to-output latency is 1 cycle. A push at edge N makes the entry visible on `out_*` after edge N when the queue was empty.
- A pop at edge N exposes the next entry after edge N.
- `full` and `in_ready` are registered-state functions, so they update the cycle after the push that fills or the pop that frees.
- Flush at edge N gives `out_valid=0` and `in_ready=1` after edge N. A push presented in the cycle after the flush is accepted.
- Sustained throughput is one push and one pop per cycle at any occupancy below full.

## Test plan
- Reset/empty: hold `reset=0`, then release. Required: `out_valid=0`, `out_instr=0x00000013`, `out_pc=0`, `count=0`, `in_ready=1`.
- Fill and drain: push PCs `0x1000`, `0x1004`, `0x1008`, `0x100C` with `out_ready=0`. Required: `count=4`, `full=1`, `in_ready=0`. Then push `0x1010`: it is dropped. Then set `out_ready=1`: outputs appear in order `0x1000`..`0x100C`, then `out_valid=0`.
- Wrap-around: run 10 pushes and pops interleaved at steady `count=2`. Required: PCs exit in push order across pointer wrap, and `count` stays 2.
- Simultaneous push/pop at `count=3`: push `0x2000` while popping the head. Required: `count` stays 3 and `0x2000` appears after the existing two remaining entries.
- Flush with concurrent push/pop: at `count=3`, assert `flush`, `in_valid` (`0x3000`) and `out_ready` together. Required: next cycle `count=0`, `out_valid=0`, and `0x3000` is never output. A push of `0x4000` in the following cycle is the next output.
- Async reset mid-operation: at `count=2`, drop `reset` between edges. Required: `out_valid=0` and `count=0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between the icache and decode.
// Holds {pc, instr} pairs; head shown combinationally; flush empties the queue.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int INSTSZ = 32,
   parameter int WORDSZ = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [INSTSZ-1:0]        in_instr,
   input  logic [WORDSZ-1:0]        in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [INSTSZ-1:0]        out_instr,
   output logic [WORDSZ-1:0]        out_pc,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [INSTSZ-1:0] NOP_INSTR = INSTSZ'(32'h0000_0013);

   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [WORDSZ-1:0] r_pc    [DEPTH];
   logic [INSTSZ-1:0] r_instr [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // No pop-through-full: acceptance depends only on registered occupancy.
   assign w_push  = in_valid && !w_full && !flush;
   assign w_pop   = !w_empty && out_ready && !flush;

   // Payload storage carries no reset; validity is tracked by r_count alone.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == PW'(gi))) begin
               r_pc[gi]    <= in_pc;
               r_instr[gi] <= in_instr;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign in_ready  = !w_full;
   assign full      = w_full;
   assign count     = r_count;
   assign out_valid = !w_empty;
   assign out_instr = w_empty ? NOP_INSTR : r_instr[r_rd_ptr];
   assign out_pc    = w_empty ? '0 : r_pc[r_rd_ptr];

endmodule
